// File: rtl/mux_pkg.sv
// mux_pkg: shared helpers for onehot_arb_mux (one-hot decode, one-hot test, pointer reset value)
// Ports: none (package).
package mux_pkg;
    localparam int NMAX = 32;
    localparam int PTR_RST = 0;

    // ORs together every set bit's index, so a true one-hot input decodes exactly.
    function automatic logic [4:0] onehot_to_idx(input logic [NMAX-1:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < NMAX; i++)
            if (v[i]) r = r | 5'(i);
        return r;
    endfunction

    function automatic logic is_onehot(input logic [NMAX-1:0] v);
        return (v != '0) && ((v & (v - NMAX'(1))) == '0);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, searches req starting at ptr and wrapping mod N
// Ports: req (N requests), ptr (current top-priority index), en (transfer taken this cycle),
//        gnt (one-hot grant, 0 if no request), next_ptr (granted index + 1 mod N when en, else ptr).
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int LOG2N = 3
) (
    input  logic [N-1:0]     req,
    input  logic [LOG2N-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [LOG2N-1:0] next_ptr
);
    logic [LOG2N-1:0] j;
    logic [LOG2N-1:0] idx;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        gnt = '0;
        j   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = LOG2N'((int'(ptr) + k) % N);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
            end
        end
    end

    assign idx      = LOG2N'(onehot_to_idx(NMAX'(gnt)));
    assign next_ptr = (en && gnt != '0) ? ((int'(idx) == N - 1) ? '0 : idx + LOG2N'(1)) : ptr;
endmodule

// File: rtl/onehot_arb_mux.sv
// onehot_arb_mux: N-channel K-bit registered mux with one-hot override or round-robin selection
// Ports: clk, rst_n (async active-low); in_valid/in_data/in_ready (per-channel handshake);
//        s (one-hot override, 0 = arbiter mode); out_valid/out_data/out_grant/out_ready (output stage);
//        sel_err (sticky multi-hot select flag), err_clr (clears sel_err).
module onehot_arb_mux
    import mux_pkg::*;
#(
    parameter int K     = 8,
    parameter int N     = 8,
    parameter int LOG2N = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*K-1:0] in_data,
    output logic [N-1:0]   in_ready,
    input  logic [N-1:0]   s,
    output logic           out_valid,
    output logic [K-1:0]   out_data,
    output logic [N-1:0]   out_grant,
    input  logic           out_ready,
    output logic           sel_err,
    input  logic           err_clr
);
    logic             load;
    logic             arb_mode;
    logic             s_one;
    logic             s_multi;
    logic [N-1:0]     arb_gnt;
    logic [N-1:0]     gnt;
    logic [LOG2N-1:0] ptr;
    logic [LOG2N-1:0] next_ptr;
    logic [LOG2N-1:0] sel_idx;

    assign load     = ~out_valid | out_ready;
    assign arb_mode = (s == '0);
    assign s_one    = is_onehot(NMAX'(s));
    assign s_multi  = ~arb_mode & ~s_one;
    // A multi-hot select yields no grant at all.
    assign gnt      = arb_mode ? arb_gnt : (s_one ? (s & in_valid) : '0);
    // rst_n gate keeps every in_ready low while reset is held.
    assign in_ready = gnt & {N{load & rst_n}};
    assign sel_idx  = LOG2N'(onehot_to_idx(NMAX'(gnt)));

    rr_arbiter #(.N(N), .LOG2N(LOG2N)) u_arb (
        .req      (in_valid),
        .ptr      (ptr),
        .en       (arb_mode & load),
        .gnt      (arb_gnt),
        .next_ptr (next_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
            ptr       <= LOG2N'(PTR_RST);
            sel_err   <= 1'b0;
        end else begin
            if (load) out_valid <= (gnt != '0);
            if (load && gnt != '0) begin
                out_data  <= in_data[sel_idx*K +: K];
                out_grant <= gnt;
            end
            ptr     <= next_ptr;
            sel_err <= s_multi | (sel_err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_onehot_arb_mux.sv
// tb_onehot_arb_mux: self-checking bench for onehot_arb_mux (vector table, corner sequences, random vs model)
module tb_onehot_arb_mux;
    localparam int N = 8, K = 8, LOG2N = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   in_valid = '0;
    logic [N*K-1:0] in_data = '0;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   s = '0;
    logic           out_valid;
    logic [K-1:0]   out_data;
    logic [N-1:0]   out_grant;
    logic           out_ready = 1'b0;
    logic           sel_err;
    logic           err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    logic           m_ov, m_err;
    logic [K-1:0]   m_od;
    logic [N-1:0]   m_og;
    int             m_ptr;
    logic [N-1:0]   last_rdy;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] sel;
        logic         r;
        logic         c;
        logic [N-1:0] rdy;
        logic         ov;
        logic [K-1:0] od;
        logic [N-1:0] og;
        logic         err;
    } vec_t;
    vec_t tbl [13];

    always #5 clk = ~clk;

    onehot_arb_mux #(.K(K), .N(N), .LOG2N(LOG2N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .s         (s),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_grant (out_grant),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .err_clr   (err_clr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference selection straight from the rules: -1 means no candidate.
    function automatic int cand(input logic [N-1:0] v, input logic [N-1:0] sel);
        if (sel == '0) begin
            for (int k = 0; k < N; k++)
                if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
            return -1;
        end
        if ($countones(sel) != 1) return -1;
        for (int j = 0; j < N; j++)
            if (sel[j]) return v[j] ? j : -1;
        return -1;
    endfunction

    task automatic model_reset();
        m_ov = 1'b0; m_err = 1'b0; m_od = '0; m_og = '0; m_ptr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = '0; s = '0; out_ready = 1'b0; err_clr = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, check in_ready against the model, advance model, check registers.
    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] sel, input logic r, input logic c);
        int   ci;
        logic ld;
        in_valid = v; s = sel; out_ready = r; err_clr = c;
        #1;
        ci = cand(v, sel);
        ld = !m_ov || r;
        last_rdy = in_ready;
        chk("in_ready", 64'(in_ready), (ld && ci >= 0) ? (64'(1) << ci) : 64'(0));
        if (ld) begin
            m_ov = (ci >= 0);
            if (ci >= 0) begin
                m_od = in_data[ci*K +: K];
                m_og = N'(1) << ci;
                if (sel == '0) m_ptr = (ci + 1) % N;
            end
        end
        if (sel != '0 && $countones(sel) != 1) m_err = 1'b1;
        else if (c) m_err = 1'b0;
        @(posedge clk); #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_data", 64'(out_data), 64'(m_od));
        chk("out_grant", 64'(out_grant), 64'(m_og));
        chk("sel_err", 64'(sel_err), 64'(m_err));
    endtask

    initial begin
        logic [N-1:0] rv, rs;
        tbl[0]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{8'h08, 8'h00, 1'b0, 1'b0, 8'h08, 1'b1, 8'h13, 8'h08, 1'b0};
        tbl[2]  = '{8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h13, 8'h08, 1'b0};
        tbl[3]  = '{8'h09, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 8'h10, 8'h01, 1'b0};
        tbl[4]  = '{8'hFF, 8'h03, 1'b1, 1'b0, 8'h00, 1'b0, 8'h10, 8'h01, 1'b1};
        tbl[5]  = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h02, 1'b1, 8'h11, 8'h02, 1'b1};
        tbl[6]  = '{8'hFF, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1, 8'h12, 8'h04, 1'b0};
        tbl[7]  = '{8'hFF, 8'h81, 1'b1, 1'b1, 8'h00, 1'b0, 8'h12, 8'h04, 1'b1};
        tbl[8]  = '{8'hFF, 8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 8'h17, 8'h80, 1'b0};
        tbl[9]  = '{8'h7F, 8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 8'h17, 8'h80, 1'b0};
        tbl[10] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h08, 1'b1, 8'h13, 8'h08, 1'b0};
        tbl[11] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h13, 8'h08, 1'b0};
        tbl[12] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h13, 8'h08, 1'b0};

        @(posedge clk); #1;
        do_reset();
        for (int i = 0; i < N; i++) in_data[i*K +: K] = 8'(8'h10 + i);
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].r, tbl[i].c);
            chk($sformatf("tbl%0d_rdy", i), 64'(last_rdy), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_ov", i), 64'(out_valid), 64'(tbl[i].ov));
            chk($sformatf("tbl%0d_od", i), 64'(out_data), 64'(tbl[i].od));
            chk($sformatf("tbl%0d_og", i), 64'(out_grant), 64'(tbl[i].og));
            chk($sformatf("tbl%0d_err", i), 64'(sel_err), 64'(tbl[i].err));
        end

        // Fairness: all channels valid, data equals channel number.
        do_reset();
        for (int i = 0; i < N; i++) in_data[i*K +: K] = 8'(i);
        for (int k = 0; k < 9; k++) begin
            drive(8'hFF, 8'h00, 1'b1, 1'b0);
            chk("fair_data", 64'(out_data), 64'(k % N));
            chk("fair_grant", 64'(out_grant), 64'(1) << (k % N));
        end

        // Backpressure: hold A5 for four stalled cycles, then drain and reload at once.
        do_reset();
        in_data[3*K +: K] = 8'hA5;
        in_data[2*K +: K] = 8'h5A;
        drive(8'h08, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(8'h0C, 8'h00, 1'b0, 1'b0);
            chk("bp_rdy", 64'(last_rdy), 64'(0));
            chk("bp_data", 64'(out_data), 64'(8'hA5));
        end
        drive(8'h0C, 8'h00, 1'b1, 1'b0);
        chk("bp_drain_rdy", 64'(last_rdy), 64'(8'h04));
        chk("bp_next", 64'(out_data), 64'(8'h5A));

        // Override: one arbiter grant moves ptr to 1, override must leave it there.
        do_reset();
        for (int i = 0; i < N; i++) in_data[i*K +: K] = 8'(i);
        drive(8'hFF, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(8'hFF, 8'h20, 1'b1, 1'b0);
            chk("ovr_rdy", 64'(last_rdy), 64'(8'h20));
            chk("ovr_grant", 64'(out_grant), 64'(8'h20));
        end
        drive(8'hFF, 8'h00, 1'b1, 1'b0);
        chk("ovr_ptr_kept", 64'(out_grant), 64'(8'h02));

        // Mid-stream reset with out_valid=1 and ptr=5.
        do_reset();
        for (int k = 0; k < 5; k++) drive(8'hFF, 8'h00, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_ov", 64'(out_valid), 64'(0));
        chk("mrst_od", 64'(out_data), 64'(0));
        chk("mrst_og", 64'(out_grant), 64'(0));
        chk("mrst_rdy", 64'(in_ready), 64'(0));
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(8'hFF, 8'h00, 1'b1, 1'b0);
        chk("mrst_first", 64'(out_grant), 64'(8'h01));

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            in_data = {$urandom, $urandom};
            rv = 8'($urandom);
            if ($urandom_range(9) < 5) rs = '0;
            else if ($urandom_range(9) < 7) rs = N'(1) << $urandom_range(N - 1);
            else begin
                rs = 8'($urandom);
                if ($countones(rs) < 2) rs = 8'hC0;
            end
            drive(rv, rs, 1'($urandom_range(1)), ($urandom_range(9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
